// File: rtl/align_shift_ctrl.sv
// Alignment shift sequencer for the FPU-16 adder: drives the mantissa shift register
// for a clamped number of right shifts, gathers the sticky bit and pulses done.
module align_shift_ctrl #(
   parameter int N   = 14,
   parameter int SHW = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [SHW-1:0] shamt,
   input  logic           flush,
   input  logic           lsb_in,
   output logic           sh_ena,
   output logic           sh_sin,
   output logic           sticky,
   output logic           busy,
   output logic           done,
   output logic [SHW-1:0] remain
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [SHW-1:0] NMAX = SHW'(N);
   localparam logic [SHW-1:0] ONE  = SHW'(1);

   state_t         state_q, state_d;
   logic [SHW-1:0] remain_q, remain_d;
   logic           sticky_q, sticky_d;
   logic [SHW-1:0] eff;

   // Beyond N shifts the register is already all zeros, so extra shifts add nothing.
   assign eff = (shamt > NMAX) ? NMAX : shamt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         remain_q <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      sticky_d = sticky_q;
      if (flush) begin
         state_d  = S_IDLE;
         remain_d = '0;
         sticky_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  sticky_d = 1'b0;
                  remain_d = eff;
                  state_d  = (eff == '0) ? S_DONE : S_SHIFT;
               end else if (state_q == S_DONE) begin
                  state_d = S_IDLE;
               end
            end
            S_SHIFT: begin
               // lsb_in is the bit leaving the register on this same edge.
               sticky_d = sticky_q | lsb_in;
               remain_d = remain_q - ONE;
               if (remain_q == ONE) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign sh_ena = (state_q == S_SHIFT);
   assign busy   = (state_q == S_SHIFT);
   assign done   = (state_q == S_DONE);
   assign sh_sin = 1'b0;
   assign sticky = sticky_q;
   assign remain = remain_q;

endmodule

// File: tb/tb_align_shift_ctrl.sv
// Bench for align_shift_ctrl: a behavioural 14-bit shift register plus directed and
// random alignment ops, each checked against shift count, done timing and sticky value.
module tb_align_shift_ctrl;
   localparam int N   = 14;
   localparam int SHW = 5;

   logic           clk = 1'b0;
   logic           rst, start, flush, lsb_in;
   logic [SHW-1:0] shamt;
   logic           sh_ena, sh_sin, sticky, busy, done;
   logic [SHW-1:0] remain;
   logic [N-1:0]   treg, load_val;
   logic           load_en;
   int             n_tests = 0;
   int             n_fail  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_en)     treg <= load_val;
      else if (sh_ena) treg <= {sh_sin, treg[N-1:1]};
   end
   assign lsb_in = treg[0];

   align_shift_ctrl #(.N(N), .SHW(SHW)) dut (
      .clk(clk), .rst(rst), .start(start), .shamt(shamt), .flush(flush),
      .lsb_in(lsb_in), .sh_ena(sh_ena), .sh_sin(sh_sin), .sticky(sticky),
      .busy(busy), .done(done), .remain(remain)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int clamp(input int sa);
      return (sa > N) ? N : sa;
   endfunction

   // Sticky is set iff any of the eff lowest bits of the loaded value is one.
   function automatic logic model_sticky(input logic [N-1:0] v, input int eff);
      for (int i = 0; i < eff; i++) if (v[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run_op(input string nm, input logic [N-1:0] val, input int sa);
      int eff;
      eff      = clamp(sa);
      start    = 1'b1;
      shamt    = SHW'(sa);
      load_en  = 1'b1;
      load_val = val;
      tick();
      start   = 1'b0;
      load_en = 1'b0;
      chk($sformatf("%s remain0", nm), remain, eff);
      for (int k = 1; k <= eff; k++) begin
         chk($sformatf("%s ena c%0d", nm, k), {sh_ena, busy, done}, 3'b110);
         tick();
      end
      chk($sformatf("%s done", nm), {sh_ena, busy, done}, 3'b001);
      chk($sformatf("%s sticky", nm), sticky, model_sticky(val, eff));
      chk($sformatf("%s reg", nm), treg, val >> eff);
      tick();
      chk($sformatf("%s idle", nm), {sh_ena, done}, 2'b00);
   endtask

   initial begin
      int n_ena, dcyc, got;
      logic st;
      rst = 1'b0; start = 1'b0; flush = 1'b0; shamt = '0;
      load_en = 1'b1; load_val = '0;
      #1;
      chk("reset outs", {sh_ena, busy, done, sticky, remain}, 0);
      chk("sh_sin", sh_sin, 1'b0);
      tick(); tick();
      rst = 1'b1;
      load_en = 1'b0;
      tick();
      chk("post reset idle", {sh_ena, busy, done}, 3'b000);

      // Async reset in the middle of a shift sequence
      start = 1'b1; shamt = 5'd10; load_en = 1'b1; load_val = 14'h3FFF;
      tick();
      start = 1'b0; load_en = 1'b0;
      tick(); tick();
      chk("pre-reset busy/sticky", {busy, sticky}, 2'b11);
      #2 rst = 1'b0;
      #1;
      chk("async reset outs", {sh_ena, busy, done, sticky, remain}, 0);
      tick();
      rst = 1'b1;
      n_ena = 0;
      for (int c = 0; c < 4; c++) begin
         if (sh_ena || done) n_ena++;
         tick();
      end
      chk("no activity after reset", n_ena, 0);

      run_op("sh3", 14'b00000000000101, 3);
      run_op("sh0", 14'h2AB5, 0);
      run_op("sh20", 14'h2000, 20);
      run_op("sh14", 14'h0001, 14);

      // Start during SHIFT is ignored
      start = 1'b1; shamt = 5'd5; load_en = 1'b1; load_val = 14'h001F;
      tick();
      start = 1'b0; load_en = 1'b0;
      n_ena = 0; dcyc = 0; got = 0; st = 1'b0;
      for (int c = 1; c <= 20 && got == 0; c++) begin
         if (c == 2) begin start = 1'b1; shamt = 5'd2; end
         if (sh_ena) n_ena++;
         if (done) begin got = 1; dcyc = c; st = sticky; end
         tick();
         start = 1'b0;
      end
      chk("ignore start done seen", got, 1);
      chk("ignore start shifts", n_ena, 5);
      chk("ignore start done cyc", dcyc, 6);
      chk("ignore start sticky", st, 1'b1);

      // Flush in the third cycle of a new op
      start = 1'b1; shamt = 5'd6; load_en = 1'b1; load_val = 14'h3FFF;
      tick();
      start = 1'b0; load_en = 1'b0;
      tick(); tick();
      chk("pre-flush sticky", {busy, sticky}, 2'b11);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush outs", {sh_ena, busy, done, sticky, remain}, 0);
      n_ena = 0;
      for (int c = 0; c < 8; c++) begin
         if (sh_ena || done) n_ena++;
         tick();
      end
      chk("no done after flush", n_ena, 0);

      // Back-to-back: second start held during done of the first op
      start = 1'b1; shamt = 5'd1; load_en = 1'b1; load_val = 14'h0001;
      tick();
      start = 1'b0; load_en = 1'b0;
      chk("b2b op1 shift", {sh_ena, done}, 2'b10);
      tick();
      chk("b2b op1 done", {done, sticky}, 2'b11);
      start = 1'b1; shamt = 5'd2; load_en = 1'b1; load_val = 14'h3FFC;
      tick();
      start = 1'b0; load_en = 1'b0;
      chk("b2b op2 c1", {sh_ena, done, sticky, remain}, {3'b100, 5'd2});
      tick();
      chk("b2b op2 c2", {sh_ena, done}, 2'b10);
      tick();
      chk("b2b op2 done", {done, sticky}, 2'b10);
      tick();
      chk("b2b idle", {sh_ena, done}, 2'b00);

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         run_op($sformatf("rnd%0d", i), N'($urandom), int'($urandom_range(0, 31)));
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
